// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Latency: WIDTH+2 cycles from start to done (MULT_SEQ_EARLY_TERM_EN: highest set bit of |B| + 3, min 3).
// Backpressure: result and done held in DONE until ack; start is ignored outside IDLE and never queued.
module mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               ack,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_RUN  = 4'b0010,
      S_FIX  = 4'b0100,
      S_DONE = 4'b1000
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_neg;
   logic [2*WIDTH-1:0]   r_product;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic                 w_run_last;

   // Magnitudes of the operands; the most negative value maps to 2^(WIDTH-1) unsigned.
   assign w_a_mag = (signed_mode && multiplicand[WIDTH-1]) ? (~multiplicand + 1'b1) : multiplicand;
   assign w_b_mag = (signed_mode && multiplier[WIDTH-1])   ? (~multiplier + 1'b1)   : multiplier;

`ifdef MULT_SEQ_EARLY_TERM_EN
   // Stop as soon as no set multiplier bits remain after this shift.
   assign w_run_last = (r_mplier[WIDTH-1:1] == '0) || (r_cnt == LAST_CNT);
`else
   assign w_run_last = (r_cnt == LAST_CNT);
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode; start only matters in IDLE, ack only in DONE.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_run_last) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_DONE;
         S_DONE:  if (ack) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand capture, one shift-add step per RUN cycle, sign fix into the product.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_product <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_neg    <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                  r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            S_RUN: begin
               if (r_mplier[0]) r_acc <= r_acc + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
            end
            S_FIX: begin
               r_product <= r_neg ? (~r_acc + 1'b1) : r_acc;
            end
            default: begin
            end
         endcase
      end
   end

   assign product = r_product;
   assign busy    = (r_state == S_RUN) || (r_state == S_FIX);
   assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, ack = 1'b0, sm = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [63:0] product;
   logic        busy, done;

   logic        start8 = 1'b0, ack8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] product8;
   logic        busy8, done8;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   mult_seq #(.WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .start(start), .ack(ack), .signed_mode(sm),
      .multiplicand(a), .multiplier(b), .product(product), .busy(busy), .done(done)
   );

   mult_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .ack(ack8), .signed_mode(1'b0),
      .multiplicand(a8), .multiplier(b8), .product(product8), .busy(busy8), .done(done8)
   );

   // Expected cycles from the start-sampling edge to done being visible.
   function automatic int exp_lat(input int w, input logic [31:0] bv, input logic s);
`ifdef MULT_SEQ_EARLY_TERM_EN
      logic [32:0] mask, mag;
      int msb;
      mask = (33'd1 << w) - 33'd1;
      mag  = {1'b0, bv} & mask;
      if (s && bv[w-1]) mag = (~mag + 33'd1) & mask;
      msb = -1;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      return (msb < 0) ? 3 : msb + 3;
`else
      if (s) return w + 2;
      return w + 2 + int'(bv[0] & 1'b0);
`endif
   endfunction

   function automatic logic [63:0] model(input logic [31:0] av, input logic [31:0] bv, input logic s);
      if (s) return longint'($signed(av)) * longint'($signed(bv));
      return {32'b0, av} * {32'b0, bv};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one 32-bit op; called at #1 after an edge with the DUT idle.
   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                         input logic [63:0] expv, input string name);
      int lat, bcnt, want;
      logic [63:0] e;
      sb.push_back(expv);
      want = exp_lat(32, bv, s);
      a = av; b = bv; sm = s; start = 1'b1;
      lat = 0; bcnt = 0;
      while (lat < 200) begin
         tick();
         start = 1'b0;
         lat++;
         if (busy) bcnt++;
         if (busy && done) begin
            errors++;
            $display("FAIL %s busy_and_done both high", name);
         end
         if (done) break;
      end
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL %s timeout waiting for done", name);
      end
      checks++;
      if (lat !== want) begin
         errors++; $display("FAIL %s latency got %0d want %0d", name, lat, want);
      end
      checks++;
      if (bcnt !== want - 1) begin
         errors++; $display("FAIL %s busy cycles got %0d want %0d", name, bcnt, want - 1);
      end
      checks++;
      if (product !== e) begin
         errors++; $display("FAIL %s product got %h want %h", name, product, e);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== e) begin
         errors++;
         $display("FAIL %s after_ack done=%b busy=%b product=%h want 0 0 %h", name, done, busy, product, e);
      end
   endtask

   task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expv,
                          input string name);
      int lat, want;
      logic [15:0] e;
      want = exp_lat(8, {24'b0, bv}, 1'b0);
      e = expv;
      a8 = av; b8 = bv; start8 = 1'b1;
      lat = 0;
      while (lat < 100) begin
         tick();
         start8 = 1'b0;
         lat++;
         if (done8) break;
      end
      checks++;
      if (done8 !== 1'b1 || lat !== want) begin
         errors++; $display("FAIL %s done=%b latency got %0d want %0d", name, done8, lat, want);
      end
      checks++;
      if (product8 !== e) begin
         errors++; $display("FAIL %s product got %h want %h", name, product8, e);
      end
      ack8 = 1'b1;
      tick();
      ack8 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
         errors++; $display("FAIL reset32 busy=%b done=%b product=%h want 0 0 0", busy, done, product);
      end
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'd0) begin
         errors++; $display("FAIL reset8 busy=%b done=%b product=%h want 0 0 0", busy8, done8, product8);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_unsigned();
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
      run_op(32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB, "u_m3x7");
   endtask

   task automatic test_signed();
      run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "s_m3x7");
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minxmin");
      run_op(32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, "s_minx1");
   endtask

   task automatic test_random();
      logic [31:0] ra, rb;
      logic rs;
      for (int i = 0; i < 6; i++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
         if (i == 1) rb = 32'h0000_0013;
         run_op(ra, rb, rs, model(ra, rb, rs), "random");
      end
   endtask

   task automatic test_handshake();
      logic [63:0] e;
      int lat;
      sb.push_back(64'd600);
      a = 32'd200; b = 32'd3; sm = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; a = 32'd11; b = 32'd13;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (!done && lat < 200) begin
         tick();
         lat++;
      end
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1 || product !== e) begin
         errors++; $display("FAIL hs_result done=%b product=%h want 1 %h", done, product, e);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (done !== 1'b1 || busy !== 1'b0 || product !== e) begin
            errors++; $display("FAIL hs_hold done=%b busy=%b product=%h want 1 0 %h", done, busy, product, e);
         end
      end
      start = 1'b1; ack = 1'b1; a = 32'd9; b = 32'd9;
      tick();
      start = 1'b0; ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || product !== e) begin
            errors++; $display("FAIL hs_idle done=%b busy=%b product=%h want 0 0 %h", done, busy, product, e);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_run();
      a = 32'hDEAD_BEEF; b = 32'h1234_5677; sm = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (busy !== 1'b1 && exp_lat(32, b, 1'b0) > 12) begin
         errors++; $display("FAIL midrun_busy got %b want 1", busy);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
         errors++; $display("FAIL midrun_reset busy=%b done=%b product=%h want 0 0 0", busy, done, product);
      end
      rst = 1'b0;
      tick();
      run_op(32'd6, 32'd7, 1'b0, 64'd42, "after_reset");
   endtask

   task automatic test_width8();
      run_op8(8'd200, 8'd3, 16'h0258, "w8_200x3");
      run_op8(8'd5, 8'd0, 16'h0000, "w8_5x0");
      run_op8(8'd255, 8'd255, 16'hFE01, "w8_max");
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_handshake();
      test_reset_mid_run();
      test_random();
      test_width8();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard leftover got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
